pwm_bank: RTL and testbench

Parametrised, double-buffered PWM channel bank that replaces the fixed 8×16-bit PWM and its value array in the top level. It sits directly on the serial reader's data/address/strobe write bus, decodes its own address window, and holds per-channel shadow and active duty registers. It drives one PWM output per channel. New duty values take effect only at a PWM period boundary, so outputs never glitch mid-period.

---
 rtl/pwm_bank_pkg.sv | 20 ++
 rtl/pwm_bank_channel.sv | 54 +++++
 rtl/pwm_bank.sv | 125 ++++++++++++
 tb/tb_pwm_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Shared constants, helpers and types for the double-buffered PWM bank.
// Optional build macro: PWM_BANK_STAGGER_EN (per-channel phase offsets).
package pwm_bank_pkg;

    localparam int MAX_WIDTH       = 16;
    localparam int CTRL_ENABLE_BIT = 0;

    // Write-bus data word; channels use the low WIDTH bits of it.
    typedef logic [MAX_WIDTH-1:0] duty_t;

    // The control register sits directly after the last channel slot.
    function automatic int ctrl_offset(input int channels);
        return channels;
    endfunction

    function automatic int period(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: active duty register, optional phase offset,
// comparator and registered output. Macro: PWM_BANK_STAGGER_EN.
module pwm_bank_channel
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef PWM_BANK_STAGGER_EN
    ,
    parameter int OFFSET = 0
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] shadow,
    input  logic             commit,
    input  logic             enable,
    output logic             pwm
);

    localparam int PERIOD = period(WIDTH);

    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] phase;

`ifdef PWM_BANK_STAGGER_EN
    logic [WIDTH:0] sum;

    // cnt + offset never reaches 2*PERIOD, so one subtract suffices.
    always_comb begin
        sum = {1'b0, cnt} + (WIDTH+1)'(OFFSET);
        if (sum >= (WIDTH+1)'(PERIOD)) begin
            phase = WIDTH'(sum - (WIDTH+1)'(PERIOD));
        end else begin
            phase = sum[WIDTH-1:0];
        end
    end
`else
    assign phase = cnt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            pwm <= enable & (phase < active);
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Double-buffered PWM channel bank on the serial write bus.
// Optional build macro: PWM_BANK_STAGGER_EN (staggered channel phases).
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int WIDTH     = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  duty_t               wr_data,
    input  logic [10:0]         wr_address,
    input  logic                wr_strobe,
    output logic [CHANNELS-1:0] outputs,
    output logic                period_start,
    output logic                pending
);

    localparam int PERIOD      = period(WIDTH);
    localparam int CTRL_OFFSET = ctrl_offset(CHANNELS);
    localparam int IDX_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

    if (CHANNELS < 1 || CHANNELS > 16 ||
        (CHANNELS & (CHANNELS - 1)) != 0) begin : g_bad_channels
        $error("pwm_bank: CHANNELS must be a power of two in 1..16");
    end

    if (WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("pwm_bank: WIDTH must be in 4..16");
    end

    if (BASE_ADDR < 0 || BASE_ADDR + CHANNELS >= 2048) begin : g_bad_base
        $error("pwm_bank: address window exceeds the 11-bit bus");
    end

    if (WIDTH < MAX_WIDTH) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^wr_data[MAX_WIDTH-1:WIDTH];
    end

    logic [WIDTH-1:0] cnt;
    logic             enable;
    logic [WIDTH-1:0] shadow [CHANNELS];

    logic [10:0]      rel;
    logic [IDX_W-1:0] idx;
    logic             shadow_hit;
    logic             ctrl_hit;
    logic             wrap;
    logic             commit;

    // Addresses below the window wrap to large values and miss.
    assign rel        = wr_address - 11'(BASE_ADDR);
    assign idx        = rel[IDX_W-1:0];
    assign shadow_hit = wr_strobe && (rel < 11'(CHANNELS));
    assign ctrl_hit   = wr_strobe && (rel == 11'(CTRL_OFFSET));
    assign wrap       = (cnt == LAST);
    assign commit     = wrap && pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            enable       <= 1'b1;
            pending      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= wrap ? '0 : cnt + WIDTH'(1);
            period_start <= wrap;
            if (ctrl_hit) begin
                enable <= wr_data[CTRL_ENABLE_BIT];
            end
            // A write landing on the wrap edge keeps pending for next time.
            if (shadow_hit) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (shadow_hit) begin
            shadow[idx] <= wr_data[WIDTH-1:0];
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef PWM_BANK_STAGGER_EN
        localparam int OFF = i << (WIDTH - $clog2(CHANNELS));

        pwm_bank_channel #(
            .WIDTH  (WIDTH),
            .OFFSET (OFF)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .cnt    (cnt),
            .shadow (shadow[i]),
            .commit (commit),
            .enable (enable),
            .pwm    (outputs[i])
        );
`else
        pwm_bank_channel #(
            .WIDTH  (WIDTH)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .cnt    (cnt),
            .shadow (shadow[i]),
            .commit (commit),
            .enable (enable),
            .pwm    (outputs[i])
        );
`endif
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (8 channels, 8-bit duty, base 64).
// Works with or without PWM_BANK_STAGGER_EN defined.
module tb_pwm_bank;

    localparam int CH   = 8;
    localparam int W    = 8;
    localparam int BASE = 64;
    localparam int P    = 255;
    localparam int CTRL = BASE + CH;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic [15:0]   wr_data    = '0;
    logic [10:0]   wr_address = '0;
    logic          wr_strobe  = 1'b0;
    logic [CH-1:0] outputs;
    logic          period_start;
    logic          pending;

    int vectors     = 0;
    int miscompares = 0;
    int duty [CH];
    int exp_q [$];

    typedef struct {
        int ch;
        int duty;
        int high;
    } vec_t;

    vec_t tbl [7];

    pwm_bank #(
        .CHANNELS  (CH),
        .WIDTH     (W),
        .BASE_ADDR (BASE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_address   (wr_address),
        .wr_strobe    (wr_strobe),
        .outputs      (outputs),
        .period_start (period_start),
        .pending      (pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Called at a negedge; the strobe is sampled on the next posedge.
    task automatic write(input int addr, input int data);
        wr_address = 11'(addr);
        wr_data    = 16'(data);
        wr_strobe  = 1'b1;
        @(negedge clock);
        wr_strobe  = 1'b0;
    endtask

    // Returns at the negedge of the next cycle with cnt = 0.
    task automatic sync();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!period_start && n < 2 * P + 4);
        if (!period_start) check("sync_timeout", 0, 1);
    endtask

    task automatic measure(input int ch, output int high);
        high = 0;
        repeat (P) begin
            @(negedge clock);
            high += int'(outputs[ch]);
        end
    endtask

    task automatic bus_busy(output int busy);
        busy = 0;
        repeat (P) begin
            @(negedge clock);
            if (outputs != '0) busy++;
        end
    endtask

    function automatic int phase(input int i, input int c);
        int off = 0;
`ifdef PWM_BANK_STAGGER_EN
        off = i << (W - $clog2(CH));
`endif
        return (c + off) % P;
    endfunction

    // Output seen in the cycle with cnt = k reflects cnt = k-1.
    task automatic wave_check(input string name);
        int bad = 0;
        logic [CH-1:0] e;
        for (int k = 1; k <= P; k++) begin
            e = '0;
            for (int i = 0; i < CH; i++) begin
                e[i] = (phase(i, k - 1) < duty[i]);
            end
            exp_q.push_back(int'(e));
            @(negedge clock);
            if (int'(outputs) != exp_q.pop_front()) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int n;
        int early;

        tbl[0] = '{4, 1, 1};
        tbl[1] = '{6, 127, 127};
        tbl[2] = '{3, 0, 0};
        tbl[3] = '{5, 255, 255};
        tbl[4] = '{7, 254, 254};
        tbl[5] = '{3, 200, 200};
        tbl[6] = '{2, 2, 2};
        for (int i = 0; i < CH; i++) duty[i] = 0;

        repeat (3) @(negedge clock);
        check("rst_outputs", int'(outputs), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_period_start", int'(period_start), 0);
        reset = 1'b1;

        // First write mid-period: invisible until the boundary
        repeat (40) @(negedge clock);
        write(BASE, 16'h0010);
        check("a_pending_set", int'(pending), 1);
        early = 0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (outputs[0]) early++;
        end while (!period_start && n < 2 * P + 4);
        check("a_reached_boundary", int'(period_start), 1);
        check("a_early_high", early, 0);
        check("a_pending_clr", int'(pending), 0);
        duty[0] = 16;
        @(negedge clock);
        check("a_first_high", int'(outputs[0]), 1);
        sync();
        measure(0, h);
        check("a_count", h, 16);

        // Table-driven duty vectors
        foreach (tbl[v]) begin
            write(BASE + tbl[v].ch, tbl[v].duty);
            exp_q.push_back(tbl[v].high);
            check($sformatf("tbl%0d_pending_set", v), int'(pending), 1);
            sync();
            duty[tbl[v].ch] = tbl[v].duty;
            check($sformatf("tbl%0d_pending_clr", v), int'(pending), 0);
            measure(tbl[v].ch, h);
            check($sformatf("tbl%0d_high", v), h, exp_q.pop_front());
        end

        // period_start spacing and width
        sync();
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!period_start && n < 2 * P);
        check("period_spacing", n, P);
        @(negedge clock);
        check("period_start_width", int'(period_start), 0);

        // Write on the wrap edge: commit takes the pre-write shadow
        sync();
        repeat (10) @(negedge clock);
        write(BASE + 1, 8'h20);
        repeat (P - 1 - 11) @(negedge clock);
        write(BASE + 1, 8'h60);
        check("b_at_wrap", int'(period_start), 1);
        check("b_pending_kept", int'(pending), 1);
        measure(1, h);
        check("b_old_duty", h, 8'h20);
        check("b_pending_clr", int'(pending), 0);
        duty[1] = 8'h60;
        measure(1, h);
        check("b_new_duty", h, 8'h60);

        // Addresses just outside the window are ignored
        write(BASE - 1, 5);
        write(CTRL + 1, 5);
        check("ignored_addr_pending", int'(pending), 0);

        // Last write within a period wins
        write(BASE + 6, 10);
        write(BASE + 6, 90);
        sync();
        duty[6] = 90;
        measure(6, h);
        check("last_write_wins", h, 90);

        // Enable off then on
        write(BASE + 2, 8'h80);
        sync();
        duty[2] = 8'h80;
        write(CTRL, 0);
        @(negedge clock);
        check("d_off_bus", int'(outputs), 0);
        bus_busy(h);
        check("d_off_period", h, 0);
        check("d_off_pending", int'(pending), 0);
        write(CTRL, 1);
        sync();
        measure(2, h);
        check("d_resume_duty", h, 8'h80);
        check("d_no_pending", int'(pending), 0);

        // Full-bus waveform against the phase model
        sync();
        wave_check("wave_mixed");
        sync();
        for (int i = 0; i < CH; i++) write(BASE + i, 8'h40);
        sync();
        for (int i = 0; i < CH; i++) duty[i] = 8'h40;
        wave_check("wave_0x40");

        // Asynchronous reset mid-period
        repeat (20) @(negedge clock);
        check("f_pre_nonzero", int'(outputs != '0), 1);
        #2 reset = 1'b0;
        #1;
        check("f_outputs_async", int'(outputs), 0);
        check("f_pending_async", int'(pending), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < CH; i++) duty[i] = 0;
        sync();
        bus_busy(h);
        check("f_after_reset_quiet", h, 0);
        write(BASE, 8'h30);
        sync();
        measure(0, h);
        check("f_new_commit", h, 8'h30);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
